// File: rtl/rv32_pkg.sv
// Shared RV32I constants: data/address widths and the ABI register names.
package rv32_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int NREG   = 32;

   localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

   typedef logic [XLEN-1:0] xword_t;

   localparam logic [REG_AW-1:0] RA = 5'd1;
   localparam logic [REG_AW-1:0] SP = 5'd2;
   localparam logic [REG_AW-1:0] GP = 5'd3;
   localparam logic [REG_AW-1:0] TP = 5'd4;
   localparam logic [REG_AW-1:0] T0 = 5'd5;
   localparam logic [REG_AW-1:0] T1 = 5'd6;
   localparam logic [REG_AW-1:0] T2 = 5'd7;
   localparam logic [REG_AW-1:0] S0 = 5'd8;
   localparam logic [REG_AW-1:0] S1 = 5'd9;
   localparam logic [REG_AW-1:0] A0 = 5'd10;
   localparam logic [REG_AW-1:0] A1 = 5'd11;

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: x0 forced to zero, optional write-through
// forwarding, and output gating while reset is asserted.
module reg_read_port
   import rv32_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic [NREG-1:0][XLEN-1:0] regs,
   input  logic [AW-1:0]             addr,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [AW-1:0]             rd_addr,
   input  logic [XLEN-1:0]           rd_wdata,
   output logic [XLEN-1:0]           data
);

   logic hit;

   always_comb begin
      hit  = (BYPASS != 0) && we && (rd_addr != AW'(ZERO_REG)) && (rd_addr == addr);
      data = '0;
      if (!rst_n || addr == AW'(ZERO_REG)) begin
         data = '0;
      end else if (hit) begin
         data = rd_wdata;
      end else begin
         data = regs[addr];
      end
   end

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: 2 combinational reads, 1 synchronous write,
// x0 hardwired to zero, asynchronous active-low clear of every entry.
module reg_file
   import rv32_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] rd_wdata,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data
);

   logic [NREG-1:0][XLEN-1:0] regs_reg;
   logic                      rst_done_reg;
   logic                      wr_en;
   logic [1:0][AW-1:0]        rs_addr;
   logic [1:0][XLEN-1:0]      rs_data;

   // The edge that releases reset never writes, even if rst_n and clk
   // change in the same instant; rst_done_reg only rises on that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done_reg <= 1'b0;
      end else begin
         rst_done_reg <= 1'b1;
      end
   end

   assign wr_en = we && rst_done_reg && (rd_addr != AW'(ZERO_REG));

   // Entry 0 is cleared by reset and never written, so it stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_reg <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (wr_en && rd_addr == AW'(i)) begin
               regs_reg[i] <= rd_wdata;
            end
         end
      end
   end

   assign rs_addr[0] = rs1_addr;
   assign rs_addr[1] = rs2_addr;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         reg_read_port #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .AW     (AW),
            .BYPASS (BYPASS)
         ) u_port (
            .regs     (regs_reg),
            .addr     (rs_addr[gi]),
            .rst_n    (rst_n),
            .we       (we),
            .rd_addr  (rd_addr),
            .rd_wdata (rd_wdata),
            .data     (rs_data[gi])
         );
      end
   endgenerate

   assign rs1_data = rs_data[0];
   assign rs2_data = rs_data[1];

endmodule

// File: tb/tb_reg_file.sv
// Directed plus randomized checks of reg_file against an array-based model.
module tb_reg_file;
   import rv32_pkg::*;

   localparam int BYPASS = 1;

   logic              clk;
   logic              rst_n;
   logic              we;
   logic [4:0]        rs1_addr;
   logic [4:0]        rs2_addr;
   logic [4:0]        rd_addr;
   logic [31:0]       rd_wdata;
   logic [31:0]       rs1_data;
   logic [31:0]       rs2_data;

   int          checks;
   int          errors;
   int          txn;
   logic [31:0] model [32];

   reg_file #(
      .XLEN(32), .NREG(32), .AW(5), .BYPASS(BYPASS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr),
      .rd_wdata (rd_wdata),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read value straight from the architectural rules.
   function automatic logic [31:0] expect_rd(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 32'h0;
      if (BYPASS != 0 && we && rd_addr != 5'd0 && rd_addr == a) return rd_wdata;
      return model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Check both ports before the edge, then clock and update the model.
   task automatic cycle(input string tag, input logic w, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] rd, input logic [31:0] wd);
      we = w; rs1_addr = ra; rs2_addr = rb; rd_addr = rd; rd_wdata = wd;
      #2;
      check({tag, "_rs1"}, rs1_data, expect_rd(ra));
      check({tag, "_rs2"}, rs2_data, expect_rd(rb));
      $display("txn %0d %s we=%0b rd=%0d wd=%h rs1=%0d:%h rs2=%0d:%h",
               txn, tag, w, rd, wd, ra, rs1_data, rb, rs2_data);
      txn++;
      clk = 1'b1;
      if (w && rd != 5'd0) model[rd] = wd;
      #5;
      clk = 1'b0;
      #3;
   endtask

   // Reset released on the same instant as a rising edge; that edge's write is dropped.
   task automatic release_on_edge(input logic w, input logic [4:0] rd, input logic [31:0] wd);
      we = w; rd_addr = rd; rd_wdata = wd;
      #5;
      rst_n = 1'b1;
      clk   = 1'b1;
      #5;
      clk = 1'b0;
      #3;
      $display("txn %0d reset_release we=%0b rd=%0d wd=%h", txn, w, rd, wd);
      txn++;
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < 32; i++) begin
         rs1_addr = 5'(i);
         rs2_addr = 5'(31 - i);
         #1;
         check({tag, "_rs1"}, rs1_data, 32'h0);
         check({tag, "_rs2"}, rs2_data, 32'h0);
      end
   endtask

   initial begin
      checks = 0; errors = 0; txn = 0;
      clk = 1'b0; rst_n = 1'b1; we = 1'b0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0; rd_wdata = '0;
      clear_model();

      // Reset with the clock stopped.
      #3;
      rst_n = 1'b0;
      #2;
      read_all_zero("reset_noclk");
      release_on_edge(1'b0, 5'd0, 32'h0);

      // Basic write/read.
      cycle("wr_x5", 1'b1, 5'd0, 5'd0, T0, 32'hDEADBEEF);
      cycle("wr_x6", 1'b1, 5'd0, 5'd0, T1, 32'h00000001);
      cycle("rd_x5_x6", 1'b0, T0, T1, 5'd0, 32'h0);
      check("basic_x5", rs1_data, 32'hDEADBEEF);
      check("basic_x6", rs2_data, 32'h00000001);

      // x0 immutability, including during the write cycle.
      cycle("x0_wr", 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
      cycle("x0_rd", 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
      check("x0_after", rs1_data | rs2_data, 32'h0);

      // Same-cycle forwarding on both ports.
      cycle("byp_init", 1'b1, 5'd0, 5'd0, T2, 32'h11111111);
      cycle("byp_hit", 1'b1, T2, T2, T2, 32'h22222222);
      check("byp_rs1_direct", rs1_data, (BYPASS != 0) ? 32'h22222222 : 32'h11111111);
      cycle("byp_after", 1'b0, T2, T2, 5'd0, 32'h0);
      check("byp_after_direct", rs2_data, 32'h22222222);

      // Write enable gating.
      cycle("we_gate", 1'b0, 5'd0, 5'd0, S1, 32'hA5A5A5A5);
      cycle("we_gate_rd", 1'b0, S1, S1, 5'd0, 32'h0);
      check("we_gate_x9", rs1_data, 32'h0);

      // Randomized traffic; small address ranges make collisions frequent.
      for (int n = 0; n < 300; n++) begin
         logic [4:0] ra, rb, rd;
         ra = (n % 3 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         rb = (n % 3 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         rd = (n % 3 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
         cycle("rand", 1'($urandom), ra, rb, rd, $urandom);
      end

      // Reset asserted between edges after filling every register.
      for (int i = 1; i < 32; i++) cycle("fill", 1'b1, 5'd0, 5'd0, 5'(i), 32'(i));
      cycle("fill_chk", 1'b0, 5'd17, 5'd31, 5'd0, 32'h0);
      check("fill_x17", rs1_data, 32'd17);
      check("fill_x31", rs2_data, 32'd31);
      we = 1'b1; rd_addr = 5'd4; rd_wdata = 32'hCAFEF00D;
      #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      rs1_addr = 5'd4; rs2_addr = 5'd4;
      #1;
      check("rst_byp_rs1", rs1_data, 32'h0);
      check("rst_byp_rs2", rs2_data, 32'h0);
      we = 1'b0;
      read_all_zero("reset_mid");
      release_on_edge(1'b1, GP, 32'h00000055);
      cycle("rel_chk", 1'b0, GP, 5'd1, 5'd0, 32'h0);
      check("rel_x3", rs1_data, 32'h0);
      check("rel_x1", rs2_data, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
